// File: rtl/ow_arb_pkg.sv
// Shared definitions for the one-wire bus arbiter: FSM encoding, requester
// count and the status byte reported when the watchdog forces completion.
package ow_arb_pkg;

    localparam int OW_NUM_REQ = 2;

    localparam logic [7:0] OW_TIMEOUT_STATE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/ow_bus_arbiter_if.sv
// Request, bus-master command/status and response signals of the arbiter,
// bundled with an arbiter-side (slave) and environment-side (master) view.
interface ow_bus_arbiter_if;
    import ow_arb_pkg::*;

    logic [OW_NUM_REQ-1:0]   req_valid;
    logic [OW_NUM_REQ-1:0]   req_cmd;
    logic [7*OW_NUM_REQ-1:0] req_addr;
    logic [8*OW_NUM_REQ-1:0] req_num;
    logic [8*OW_NUM_REQ-1:0] req_wdata;
    logic [OW_NUM_REQ-1:0]   req_ready;

    logic       cmd;
    logic       en;
    logic [6:0] adders;
    logic [7:0] num;
    logic [7:0] wdata;

    logic [7:0] state;
    logic       state_rctrl;
    logic [7:0] rdata1;
    logic       rdata1_rctrl;
    logic [7:0] rdata2;
    logic       rdata2_rctrl;

    logic       rsp_id;
    logic [7:0] rsp_data;
    logic       rsp_data_vld;
    logic       rsp_done;
    logic [7:0] rsp_state;
    logic       rsp_timeout;
    logic       busy;

    modport slave (
        input  req_valid, req_cmd, req_addr, req_num, req_wdata,
        input  state, state_rctrl, rdata1, rdata1_rctrl, rdata2, rdata2_rctrl,
        output req_ready, cmd, en, adders, num, wdata,
        output rsp_id, rsp_data, rsp_data_vld, rsp_done, rsp_state, rsp_timeout, busy
    );

    modport master (
        output req_valid, req_cmd, req_addr, req_num, req_wdata,
        output state, state_rctrl, rdata1, rdata1_rctrl, rdata2, rdata2_rctrl,
        input  req_ready, cmd, en, adders, num, wdata,
        input  rsp_id, rsp_data, rsp_data_vld, rsp_done, rsp_state, rsp_timeout, busy
    );

endinterface

// File: rtl/ow_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that was not granted last.
module ow_rr_pick
    import ow_arb_pkg::*;
(
    input  logic [OW_NUM_REQ-1:0] req_valid,
    input  logic                  last_gnt,
    output logic                  gnt,
    output logic                  any
);

    always_comb begin
        any = |req_valid;
        if (&req_valid) begin
            gnt = ~last_gnt;
        end else begin
            gnt = req_valid[1];
        end
    end

endmodule

// File: rtl/ow_bus_arbiter.sv
// Round-robin sequencer sharing the one-wire master command port between the
// UART handler (0) and autopoll engine (1). Define OW_ARB_TIMEOUT_EN for the watchdog.
module ow_bus_arbiter
    import ow_arb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    ow_bus_arbiter_if.slave   bus
);

    if (TIMEOUT < 16'd2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    logic       cmd_arr   [OW_NUM_REQ];
    logic [6:0] addr_arr  [OW_NUM_REQ];
    logic [7:0] num_arr   [OW_NUM_REQ];
    logic [7:0] wdata_arr [OW_NUM_REQ];

    for (genvar gi = 0; gi < OW_NUM_REQ; gi++) begin : g_req
        assign cmd_arr[gi]   = bus.req_cmd[gi];
        assign addr_arr[gi]  = bus.req_addr[gi*7 +: 7];
        assign num_arr[gi]   = bus.req_num[gi*8 +: 8];
        assign wdata_arr[gi] = bus.req_wdata[gi*8 +: 8];
    end

    arb_state_t fsm_reg, fsm_next;
    logic       gnt_reg, gnt_next;
    logic       last_gnt_reg, last_gnt_next;
    logic       skid_vld_reg, skid_vld_next;
    logic [7:0] skid_data_reg, skid_data_next;

    logic [OW_NUM_REQ-1:0] req_ready_reg, req_ready_next;
    logic       cmd_reg, cmd_next;
    logic       en_reg, en_next;
    logic [6:0] adders_reg, adders_next;
    logic [7:0] num_reg, num_next;
    logic [7:0] wdata_reg, wdata_next;
    logic       rsp_id_reg, rsp_id_next;
    logic [7:0] rsp_data_reg, rsp_data_next;
    logic       rsp_data_vld_reg, rsp_data_vld_next;
    logic       rsp_done_reg, rsp_done_next;
    logic [7:0] rsp_state_reg, rsp_state_next;
    logic       busy_reg, busy_next;

    logic       pick_gnt, pick_any;
    logic       fwd_taken;
    logic       expired;

    ow_rr_pick u_pick (
        .req_valid (bus.req_valid),
        .last_gnt  (last_gnt_reg),
        .gnt       (pick_gnt),
        .any       (pick_any)
    );

`ifdef OW_ARB_TIMEOUT_EN
    logic [15:0] cnt_reg, cnt_next;
    logic        rsp_timeout_reg, rsp_timeout_next;

    assign expired = (cnt_reg == TIMEOUT - 16'd1);

    always_comb begin
        cnt_next = cnt_reg;
        if (fsm_reg == ST_ISSUE) begin
            cnt_next = '0;
        end else if (fsm_reg == ST_BUSY) begin
            cnt_next = cnt_reg + 16'd1;
        end
        // A done strobe in the expiry cycle is a normal completion.
        rsp_timeout_next = (fsm_reg == ST_BUSY) && !bus.state_rctrl && expired;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg         <= '0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_reg;
`else
    assign expired         = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        fsm_next          = fsm_reg;
        gnt_next          = gnt_reg;
        last_gnt_next     = last_gnt_reg;
        skid_vld_next     = skid_vld_reg;
        skid_data_next    = skid_data_reg;
        req_ready_next    = '0;
        cmd_next          = cmd_reg;
        en_next           = 1'b0;
        adders_next       = adders_reg;
        num_next          = num_reg;
        wdata_next        = wdata_reg;
        rsp_id_next       = rsp_id_reg;
        rsp_data_next     = rsp_data_reg;
        rsp_data_vld_next = 1'b0;
        rsp_done_next     = 1'b0;
        rsp_state_next    = rsp_state_reg;
        fwd_taken         = 1'b0;

        // The skid byte always goes first; it was captured a cycle earlier.
        if (skid_vld_reg) begin
            rsp_data_vld_next = 1'b1;
            rsp_data_next     = skid_data_reg;
            rsp_id_next       = gnt_reg;
            skid_vld_next     = 1'b0;
            fwd_taken         = 1'b1;
        end

        // The master never strobes again while a skid byte is still pending.
        if (fsm_reg == ST_BUSY) begin
            if (bus.rdata1_rctrl) begin
                if (!fwd_taken) begin
                    rsp_data_vld_next = 1'b1;
                    rsp_data_next     = bus.rdata1;
                    rsp_id_next       = gnt_reg;
                    fwd_taken         = 1'b1;
                end else begin
                    skid_vld_next  = 1'b1;
                    skid_data_next = bus.rdata1;
                end
            end
            if (bus.rdata2_rctrl) begin
                if (!fwd_taken) begin
                    rsp_data_vld_next = 1'b1;
                    rsp_data_next     = bus.rdata2;
                    rsp_id_next       = gnt_reg;
                    fwd_taken         = 1'b1;
                end else begin
                    skid_vld_next  = 1'b1;
                    skid_data_next = bus.rdata2;
                end
            end
        end

        case (fsm_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    fsm_next                 = ST_ISSUE;
                    gnt_next                 = pick_gnt;
                    en_next                  = 1'b1;
                    req_ready_next[pick_gnt] = 1'b1;
                    cmd_next                 = cmd_arr[pick_gnt];
                    adders_next              = addr_arr[pick_gnt];
                    num_next                 = num_arr[pick_gnt];
                    wdata_next               = wdata_arr[pick_gnt];
                end
            end
            ST_ISSUE: begin
                fsm_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (bus.state_rctrl) begin
                    fsm_next       = ST_DONE;
                    rsp_done_next  = 1'b1;
                    rsp_state_next = bus.state;
                    rsp_id_next    = gnt_reg;
                end else if (expired) begin
                    fsm_next       = ST_DONE;
                    rsp_done_next  = 1'b1;
                    rsp_state_next = OW_TIMEOUT_STATE;
                    rsp_id_next    = gnt_reg;
                end
            end
            ST_DONE: begin
                last_gnt_next = gnt_reg;
                fsm_next      = ST_IDLE;
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase

        busy_next = (fsm_next != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_reg          <= ST_IDLE;
            gnt_reg          <= 1'b0;
            last_gnt_reg     <= 1'b1;
            skid_vld_reg     <= 1'b0;
            skid_data_reg    <= '0;
            req_ready_reg    <= '0;
            cmd_reg          <= 1'b0;
            en_reg           <= 1'b0;
            adders_reg       <= '0;
            num_reg          <= '0;
            wdata_reg        <= '0;
            rsp_id_reg       <= 1'b0;
            rsp_data_reg     <= '0;
            rsp_data_vld_reg <= 1'b0;
            rsp_done_reg     <= 1'b0;
            rsp_state_reg    <= '0;
            busy_reg         <= 1'b0;
        end else begin
            fsm_reg          <= fsm_next;
            gnt_reg          <= gnt_next;
            last_gnt_reg     <= last_gnt_next;
            skid_vld_reg     <= skid_vld_next;
            skid_data_reg    <= skid_data_next;
            req_ready_reg    <= req_ready_next;
            cmd_reg          <= cmd_next;
            en_reg           <= en_next;
            adders_reg       <= adders_next;
            num_reg          <= num_next;
            wdata_reg        <= wdata_next;
            rsp_id_reg       <= rsp_id_next;
            rsp_data_reg     <= rsp_data_next;
            rsp_data_vld_reg <= rsp_data_vld_next;
            rsp_done_reg     <= rsp_done_next;
            rsp_state_reg    <= rsp_state_next;
            busy_reg         <= busy_next;
        end
    end

    assign bus.req_ready    = req_ready_reg;
    assign bus.cmd          = cmd_reg;
    assign bus.en           = en_reg;
    assign bus.adders       = adders_reg;
    assign bus.num          = num_reg;
    assign bus.wdata        = wdata_reg;
    assign bus.rsp_id       = rsp_id_reg;
    assign bus.rsp_data     = rsp_data_reg;
    assign bus.rsp_data_vld = rsp_data_vld_reg;
    assign bus.rsp_done     = rsp_done_reg;
    assign bus.rsp_state    = rsp_state_reg;
    assign bus.busy         = busy_reg;

endmodule

// File: tb/tb_ow_bus_arbiter.sv
// Directed bench for ow_bus_arbiter with a cycle-level reference model of the
// arbitration, forwarding and watchdog rules; honours OW_ARB_TIMEOUT_EN.
module tb_ow_bus_arbiter;
    import ow_arb_pkg::*;

    localparam logic [15:0] TO = 16'd10;
`ifdef OW_ARB_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ow_bus_arbiter_if bus ();

    ow_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: expected outputs for the cycle after each clock edge.
    int         m_phase;      // 0 idle, 1 issue, 2 busy, 3 done
    bit         m_last, m_owner, m_live;
    int         m_cnt;
    logic [7:0] m_pend [$];
    logic [1:0] e_ready;
    logic       e_cmd, e_en, e_id, e_vld, e_done, e_to, e_busy;
    logic [6:0] e_addr;
    logic [7:0] e_num, e_wdata, e_data, e_state;

    initial m_live = 1'b0;

    always @(posedge clk) begin : model
        bit took;
        int idx;
        if (!rst) begin
            m_phase = 0; m_last = 1'b1; m_owner = 1'b0; m_cnt = 0; m_pend.delete();
            e_ready = '0; e_cmd = 0; e_en = 0; e_addr = '0; e_num = '0; e_wdata = '0;
            e_id = 0; e_data = '0; e_vld = 0; e_done = 0; e_state = '0; e_to = 0; e_busy = 0;
            m_live = 1'b1;
        end else begin
            e_en = 0; e_ready = '0; e_vld = 0; e_done = 0; e_to = 0; took = 0;
            if (m_pend.size() > 0) begin
                e_data = m_pend.pop_front(); e_vld = 1; e_id = m_owner; took = 1;
            end
            if (m_phase == 2) begin
                if (bus.rdata1_rctrl) begin
                    if (!took) begin e_data = bus.rdata1; e_vld = 1; e_id = m_owner; took = 1; end
                    else m_pend.push_back(bus.rdata1);
                end
                if (bus.rdata2_rctrl) begin
                    if (!took) begin e_data = bus.rdata2; e_vld = 1; e_id = m_owner; took = 1; end
                    else m_pend.push_back(bus.rdata2);
                end
            end
            case (m_phase)
                0: if (bus.req_valid != 2'b00) begin
                    m_owner = (bus.req_valid == 2'b11) ? !m_last : bus.req_valid[1];
                    idx     = int'(m_owner);
                    e_en    = 1;
                    e_ready = 2'b01 << idx;
                    e_cmd   = bus.req_cmd[idx];
                    e_addr  = bus.req_addr[idx*7 +: 7];
                    e_num   = bus.req_num[idx*8 +: 8];
                    e_wdata = bus.req_wdata[idx*8 +: 8];
                    m_phase = 1;
                end
                1: begin m_phase = 2; m_cnt = 0; end
                2: begin
                    if (bus.state_rctrl) begin
                        e_done = 1; e_state = bus.state; e_id = m_owner; m_phase = 3;
                    end else if (WD_EN && m_cnt == int'(TO) - 1) begin
                        e_done = 1; e_state = 8'hFF; e_to = 1; e_id = m_owner; m_phase = 3;
                    end
                    m_cnt++;
                end
                default: begin m_last = m_owner; m_phase = 0; end
            endcase
            e_busy = (m_phase != 0);
        end
    end

    always @(negedge clk) begin : compare
        bit ok;
        if (m_live) begin
            ok = (bus.req_ready === e_ready) && (bus.cmd === e_cmd) && (bus.en === e_en) &&
                 (bus.adders === e_addr) && (bus.num === e_num) && (bus.wdata === e_wdata) &&
                 (bus.rsp_data_vld === e_vld) && (bus.rsp_done === e_done) &&
                 (bus.rsp_timeout === e_to) && (bus.busy === e_busy) &&
                 (!e_vld || bus.rsp_data === e_data) &&
                 (!(e_vld || e_done) || bus.rsp_id === e_id) &&
                 (!e_done || bus.rsp_state === e_state);
            vectors++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle_model t=%0t got rdy=%b en=%b cmd=%b a=%h n=%h w=%h vld=%b d=%h id=%b done=%b st=%h to=%b busy=%b required rdy=%b en=%b cmd=%b a=%h n=%h w=%h vld=%b d=%h id=%b done=%b st=%h to=%b busy=%b",
                         $time, bus.req_ready, bus.en, bus.cmd, bus.adders, bus.num, bus.wdata,
                         bus.rsp_data_vld, bus.rsp_data, bus.rsp_id, bus.rsp_done, bus.rsp_state,
                         bus.rsp_timeout, bus.busy, e_ready, e_en, e_cmd, e_addr, e_num, e_wdata,
                         e_vld, e_data, e_id, e_done, e_state, e_to, e_busy);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_en(input string name);
        int n = 0;
        while (bus.en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(bus.en), 64'd1);
    endtask

    task automatic set_req(input int i, input logic c, input logic [6:0] a,
                           input logic [7:0] n, input logic [7:0] w);
        bus.req_cmd[i]         = c;
        bus.req_addr[i*7 +: 7] = a;
        bus.req_num[i*8 +: 8]  = n;
        bus.req_wdata[i*8 +: 8] = w;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.req_ready, bus.cmd, bus.en, bus.adders, bus.num, bus.wdata,
                    bus.rsp_id, bus.rsp_data, bus.rsp_data_vld, bus.rsp_done,
                    bus.rsp_state, bus.rsp_timeout, bus.busy});
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [1:0] order [3];
        bus.req_valid = '0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_num = '0;
        bus.req_wdata = '0; bus.state = '0; bus.state_rctrl = 0; bus.rdata1 = '0;
        bus.rdata1_rctrl = 0; bus.rdata2 = '0; bus.rdata2_rctrl = 0;
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;

        repeat (3) tick();
        check("reset_outputs", all_outputs(), 64'd0);
        rst = 1'b1;

        // Single read request from req 0
        set_req(0, 1'b0, 7'h2A, 8'd2, 8'h00);
        bus.req_valid = 2'b01;
        tick();
        check("t1_en", 64'(bus.en), 64'd1);
        check("t1_ready", 64'(bus.req_ready), 64'h1);
        check("t1_adders", 64'(bus.adders), 64'h2A);
        check("t1_num", 64'(bus.num), 64'd2);
        bus.req_valid = 2'b00;
        tick();
        bus.rdata1 = 8'h11; bus.rdata1_rctrl = 1;
        tick();
        bus.rdata1_rctrl = 0;
        check("t1_byte1", 64'({bus.rsp_data_vld, bus.rsp_id, bus.rsp_data}), 64'h211);
        bus.rdata2 = 8'h22; bus.rdata2_rctrl = 1;
        tick();
        bus.rdata2_rctrl = 0;
        check("t1_byte2", 64'({bus.rsp_data_vld, bus.rsp_data}), 64'h122);
        bus.state = 8'h00; bus.state_rctrl = 1;
        tick();
        bus.state_rctrl = 0;
        check("t1_done", 64'({bus.rsp_done, bus.rsp_timeout, bus.rsp_state}), 64'h200);
        tick();
        check("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Tie from reset, then round robin while both stay valid
        do_reset();
        set_req(0, 1'b1, 7'h01, 8'h10, 8'hB0);
        set_req(1, 1'b0, 7'h02, 8'h20, 8'hB1);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            wait_en($sformatf("t2_grant%0d_en", k));
            check($sformatf("t2_grant%0d_ready", k), 64'(bus.req_ready), 64'(order[k]));
            check($sformatf("t2_grant%0d_wdata", k), 64'(bus.wdata),
                  (order[k] == 2'b10) ? 64'hB1 : 64'hB0);
            tick();
            bus.state = 8'(k + 3); bus.state_rctrl = 1;
            tick();
            bus.state_rctrl = 0;
            check($sformatf("t2_done%0d", k), 64'({bus.rsp_done, bus.rsp_id, bus.rsp_state}),
                  64'({1'b1, order[k][1], 8'(k + 3)}));
        end
        bus.req_valid = 2'b00;
        repeat (2) tick();

        // Simultaneous data strobes, then a skid byte emitted alongside done
        do_reset();
        set_req(1, 1'b0, 7'h55, 8'd4, 8'h00);
        bus.req_valid = 2'b10;
        wait_en("t3_en");
        bus.req_valid = 2'b00;
        tick();
        bus.rdata1 = 8'hA5; bus.rdata2 = 8'h5A; bus.rdata1_rctrl = 1; bus.rdata2_rctrl = 1;
        tick();
        bus.rdata1_rctrl = 0; bus.rdata2_rctrl = 0;
        check("t3_first", 64'({bus.rsp_data_vld, bus.rsp_id, bus.rsp_data}), 64'h3A5);
        tick();
        check("t3_second", 64'({bus.rsp_data_vld, bus.rsp_data}), 64'h15A);
        bus.rdata1 = 8'h33; bus.rdata2 = 8'h44; bus.rdata1_rctrl = 1; bus.rdata2_rctrl = 1;
        tick();
        bus.rdata1_rctrl = 0; bus.rdata2_rctrl = 0;
        check("t3_third", 64'({bus.rsp_data_vld, bus.rsp_done, bus.rsp_data}), 64'h233);
        bus.state = 8'h07; bus.state_rctrl = 1;
        tick();
        bus.state_rctrl = 0;
        check("t3_skid_with_done", 64'({bus.rsp_data_vld, bus.rsp_done, bus.rsp_data, bus.rsp_state}),
              64'h34407);
        repeat (2) tick();

        // Watchdog expiry and a completion that lands on the expiry cycle
        do_reset();
        set_req(0, 1'b1, 7'h3C, 8'd1, 8'h99);
        bus.req_valid = 2'b01;
        wait_en("t4_en");
        bus.req_valid = 2'b00;
        tick();
`ifdef OW_ARB_TIMEOUT_EN
        repeat (9) tick();
        check("t4_not_yet", 64'(bus.rsp_done), 64'd0);
        tick();
        check("t4_timeout", 64'({bus.rsp_done, bus.rsp_timeout, bus.rsp_state}), 64'h3FF);
        repeat (2) tick();
        bus.req_valid = 2'b01;
        wait_en("t4b_en");
        bus.req_valid = 2'b00;
        tick();
        repeat (9) tick();
        bus.state = 8'h3C; bus.state_rctrl = 1;
        tick();
        bus.state_rctrl = 0;
        check("t4_race_normal", 64'({bus.rsp_done, bus.rsp_timeout, bus.rsp_state}), 64'h23C);
`else
        repeat (30) tick();
        check("t4_waits", 64'({bus.rsp_done, bus.busy}), 64'h1);
        bus.state = 8'h3C; bus.state_rctrl = 1;
        tick();
        bus.state_rctrl = 0;
        check("t4_late_done", 64'({bus.rsp_done, bus.rsp_timeout, bus.rsp_state}), 64'h23C);
`endif
        repeat (2) tick();

        // Reset for one cycle mid-BUSY with a skid byte pending
        set_req(0, 1'b0, 7'h12, 8'd2, 8'h00);
        bus.req_valid = 2'b01;
        wait_en("t5_en");
        bus.req_valid = 2'b00;
        tick();
        bus.rdata1 = 8'h61; bus.rdata2 = 8'h62; bus.rdata1_rctrl = 1; bus.rdata2_rctrl = 1;
        tick();
        bus.rdata1_rctrl = 0; bus.rdata2_rctrl = 0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("t5_reset_outputs", all_outputs(), 64'd0);
        tick();
        check("t5_no_skid_no_done", 64'({bus.rsp_data_vld, bus.rsp_done}), 64'd0);
        set_req(1, 1'b1, 7'h4F, 8'd3, 8'hC3);
        bus.req_valid = 2'b10;
        wait_en("t5_reissue_en");
        check("t5_reissue_fields", 64'({bus.req_ready, bus.cmd, bus.adders}), 64'({2'b10, 1'b1, 7'h4F}));
        bus.req_valid = 2'b00;
        tick();
        bus.state = 8'h01; bus.state_rctrl = 1;
        tick();
        bus.state_rctrl = 0;
        check("t5_done", 64'({bus.rsp_done, bus.rsp_id, bus.rsp_state}), 64'h301);
        repeat (2) tick();

        // Stray strobes while idle
        bus.state = 8'h55; bus.state_rctrl = 1; bus.rdata1_rctrl = 1; bus.rdata2_rctrl = 1;
        tick();
        bus.state_rctrl = 0; bus.rdata1_rctrl = 0; bus.rdata2_rctrl = 0;
        check("t6_ignored", 64'({bus.rsp_done, bus.rsp_data_vld, bus.busy}), 64'd0);
        tick();
        check("t6_ignored_later", 64'({bus.rsp_done, bus.rsp_data_vld}), 64'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
